mm_seq: RTL and testbench

MM_SEQ -- requirements
Module: mm_seq

---
 rtl/mm_pkg.sv | 27 ++
 rtl/mm_row_cnt.sv | 33 +++
 rtl/mm_seq.sv | 140 ++++++++++++++
 tb/tb_mm_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mm_pkg
//  Brief    : Shared types and sizing helpers for the matrix-multiply sequencer
//  Revision : 1.0
// ============================================================================
package mm_pkg;

    // Default geometry, shared with the memA/memB row stores.
    localparam int c_dim_def     = 8;
    localparam int c_bits_ab_def = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DONE    = 3'd4
    } mm_state_t;

    // Cycles for the last skewed operand to drain through a DIM x DIM array.
    function automatic int comp_cycles(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_row_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : mm_row_cnt
//  Brief    : Up counter with clear and increment, wrapping to 0 after MAX
//  Revision : 1.0
// ============================================================================
module mm_row_cnt #(
    parameter int MAX   = 7,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;

    assign count = r_count;
    assign wrap  = (r_count == WIDTH'(MAX));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mm_seq
//  Brief    : Load A, load B, then drive a DIM x DIM systolic compute pass
//  Revision : 1.0
// ============================================================================
module mm_seq
    import mm_pkg::*;
#(
    parameter  int DIM         = c_dim_def,
    parameter  int BITS_AB     = c_bits_ab_def,
    localparam int ROWBITS     = $clog2(DIM),
    localparam int CYCBITS     = $clog2(3 * DIM - 1),
    localparam int COMP_CYCLES = comp_cycles(DIM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            in_valid,
    input  logic [DIM-1:0][BITS_AB-1:0]     in_data,
    output logic                            in_ready,
    output logic [DIM-1:0][BITS_AB-1:0]     mem_din,
    output logic                            memA_WrEn,
    output logic                            memB_WrEn,
    output logic [ROWBITS-1:0]              mem_row,
    output logic                            mem_en,
    output logic                            sa_en,
    output logic [CYCBITS-1:0]              cycle,
    output logic                            busy,
    output logic                            done
);

    mm_state_t r_state;
    mm_state_t w_next;

    logic w_row_clr, w_row_inc, w_row_wrap;
    logic w_cyc_clr, w_cyc_inc, w_cyc_wrap;
    logic w_in_ready, w_wr_a, w_wr_b, w_comp, w_busy, w_done;

    mm_row_cnt #(.MAX(DIM - 1), .WIDTH(ROWBITS)) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_row_clr),
        .inc   (w_row_inc),
        .count (mem_row),
        .wrap  (w_row_wrap)
    );

    mm_row_cnt #(.MAX(COMP_CYCLES - 1), .WIDTH(CYCBITS)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cyc_clr),
        .inc   (w_cyc_inc),
        .count (cycle),
        .wrap  (w_cyc_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_wr_a     = 1'b0;
        w_wr_b     = 1'b0;
        w_comp     = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        w_row_clr  = 1'b0;
        w_row_inc  = 1'b0;
        w_cyc_clr  = 1'b0;
        w_cyc_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start && !abort) begin
                    w_next    = S_LOAD_A;
                    w_row_clr = 1'b1;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                w_in_ready = 1'b1;
                if (abort) begin
                    w_next    = S_IDLE;
                    w_row_clr = 1'b1;
                    w_cyc_clr = 1'b1;
                end else if (in_valid) begin
                    w_wr_a    = (r_state == S_LOAD_A);
                    w_wr_b    = (r_state == S_LOAD_B);
                    w_row_inc = 1'b1;
                    if (w_row_wrap) begin
                        w_next    = (r_state == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
                        w_cyc_clr = (r_state == S_LOAD_B);
                    end
                end
            end
            S_COMPUTE: begin
                w_comp = 1'b1;
                if (abort) begin
                    w_next    = S_IDLE;
                    w_row_clr = 1'b1;
                    w_cyc_clr = 1'b1;
                end else begin
                    w_cyc_inc = 1'b1;
                    if (w_cyc_wrap) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next    = S_IDLE;
                w_done    = !abort;
                w_row_clr = abort;
                w_cyc_clr = abort;
            end
            default: begin
                w_next = S_IDLE;
                w_busy = 1'b0;
            end
        endcase
    end

    // Reset must silence every control output in the same cycle it is seen.
    assign in_ready  = rst_n & w_in_ready;
    assign memA_WrEn = rst_n & w_wr_a;
    assign memB_WrEn = rst_n & w_wr_b;
    assign mem_en    = rst_n & w_comp;
    assign sa_en     = rst_n & w_comp;
    assign busy      = rst_n & w_busy;
    assign done      = rst_n & w_done;
    assign mem_din   = in_data;

endmodule
`default_nettype wire

// File: tb/tb_mm_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_seq
//  Brief    : Randomised self-checking bench for mm_seq against a job-progress model
//  Revision : 1.0
// ============================================================================
module tb_mm_seq;

    localparam int DIM = 8;
    localparam int BITS_AB = 8;
    localparam int CC = 3 * DIM - 2;
    localparam int RB = $clog2(DIM);
    localparam int CB = $clog2(3 * DIM - 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, in_valid;
    logic [DIM-1:0][BITS_AB-1:0] in_data, mem_din;
    logic in_ready, memA_WrEn, memB_WrEn, mem_en, sa_en, busy, done;
    logic [RB-1:0] mem_row;
    logic [CB-1:0] cycle;

    int checks = 0;
    int failures = 0;

    // Job model: p counts progress through a job (A rows, B rows, compute cycles, done).
    bit active = 1'b0;
    int p = 0;
    logic [DIM-1:0][BITS_AB-1:0] ref_a [DIM];
    logic [DIM-1:0][BITS_AB-1:0] mem_a [DIM];
    int n_a, n_b, n_comp, n_done;

    mm_seq #(.DIM(DIM), .BITS_AB(BITS_AB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_din   (mem_din),
        .memA_WrEn (memA_WrEn),
        .memB_WrEn (memB_WrEn),
        .mem_row   (mem_row),
        .mem_en    (mem_en),
        .sa_en     (sa_en),
        .cycle     (cycle),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_counts();
        n_a = 0; n_b = 0; n_comp = 0; n_done = 0;
    endtask

    task automatic cyc(input bit r, input bit s, input bit a, input bit v);
        bit e_rdy, e_wa, e_wb, e_en, e_busy, e_done;
        int e_row, e_cyc;
        logic [63:0] gold, seen;
        @(negedge clk);
        rst_n = r; start = s; abort = a; in_valid = v;
        in_data = {$urandom, $urandom};
        #2;
        e_rdy = 0; e_wa = 0; e_wb = 0; e_en = 0; e_busy = 0; e_done = 0;
        e_row = 0; e_cyc = 0;
        if (r && active) begin
            e_busy = 1;
            if (p < DIM) begin
                e_rdy = 1; e_wa = v && !a; e_row = p;
            end else if (p < 2 * DIM) begin
                e_rdy = 1; e_wb = v && !a; e_row = p - DIM;
            end else if (p < 2 * DIM + CC) begin
                e_en = 1; e_cyc = p - 2 * DIM;
            end else begin
                e_done = !a;
            end
        end
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("memA_WrEn", 64'(memA_WrEn), 64'(e_wa));
        chk("memB_WrEn", 64'(memB_WrEn), 64'(e_wb));
        chk("mem_en", 64'(mem_en), 64'(e_en));
        chk("sa_en", 64'(sa_en), 64'(e_en));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("mem_din", mem_din, in_data);
        if (e_wa || e_wb) chk("mem_row", 64'(mem_row), 64'(e_row));
        if (e_wa) ref_a[e_row] = in_data;
        if (memA_WrEn) begin mem_a[mem_row] = mem_din; n_a++; end
        if (memB_WrEn) n_b++;
        if (mem_en) n_comp++;
        if (done) n_done++;
        if (e_en) begin
            chk("cycle", 64'(cycle), 64'(e_cyc));
            // Row i of A enters the array i cycles late; element k = cycle - i.
            gold = '0; seen = '0;
            for (int i = 0; i < DIM; i++) begin
                int k = e_cyc - i;
                if (k >= 0 && k < DIM) begin
                    gold[i*BITS_AB +: BITS_AB] = ref_a[i][k];
                    seen[i*BITS_AB +: BITS_AB] = mem_a[i][k];
                end
            end
            chk("a_skew", seen, gold);
        end
        if (!r) begin
            active = 0; p = 0;
        end else if (!active) begin
            if (s && !a) begin active = 1; p = 0; end
        end else if (a) begin
            active = 0;
        end else if (p < 2 * DIM) begin
            if (v) p++;
        end else if (p < 2 * DIM + CC) begin
            p++;
        end else begin
            active = 0;
        end
    endtask

    // vmode 0: always valid; 1: valid pattern 1,0,0; 2: random. noise pulses start mid-job.
    task automatic run_job(input int vmode, input bit noise);
        int k = 0;
        clr_counts();
        cyc(1, 1, 0, 0);
        while (active && k < 500) begin
            bit v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (k % 3 == 0) : 1'($urandom);
            bit s = noise && ((p == DIM + 3) || (p == 2 * DIM + 5));
            cyc(1, s, 0, v);
            k++;
        end
        chk("job_timeout", 64'(k < 500), 64'd1);
        chk("n_memA", 64'(n_a), 64'(DIM));
        chk("n_memB", 64'(n_b), 64'(DIM));
        chk("n_comp", 64'(n_comp), 64'(CC));
        chk("n_done", 64'(n_done), 64'd1);
        cyc(1, 0, 0, 0);
    endtask

    initial begin
        int k;
        rst_n = 0; start = 0; abort = 0; in_valid = 0; in_data = '0;
        for (int i = 0; i < DIM; i++) begin ref_a[i] = '0; mem_a[i] = '0; end
        clr_counts();
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 1);
        cyc(1, 0, 0, 1);

        run_job(0, 0);
        run_job(1, 0);
        run_job(0, 1);

        // Abort at compute cycle 10, then a clean job.
        clr_counts();
        cyc(1, 1, 0, 0);
        k = 0;
        while (active && k < 200) begin
            cyc(1, 0, (p == 2 * DIM + 10), 1);
            k++;
        end
        chk("abort_timeout", 64'(k < 200), 64'd1);
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_comp", 64'(n_comp), 64'd11);
        cyc(1, 0, 0, 0);
        run_job(2, 0);

        // Reset during LOAD_A after four rows, then a clean job from row 0.
        cyc(1, 1, 0, 0);
        k = 0;
        while (p < 4 && k < 50) begin cyc(1, 0, 0, 1); k++; end
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        run_job(0, 0);

        // Random soak.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 59) == 0), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
